// File: rtl/neuron_acc_if.sv
// Valid/ready bus between the adder-tree output, the accumulator and the
// activation consumer. The slave modport is the accumulator's view.
interface neuron_acc_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] bias;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_sat;

  modport master (
    output i_valid, i_data, bias, o_ready,
    input  i_ready, o_valid, o_data, o_sat
  );

  modport slave (
    input  i_valid, i_data, bias, o_ready,
    output i_ready, o_valid, o_data, o_sat
  );
endinterface

// File: rtl/neuron_acc.sv
// Accumulates NBEAT signed partial sums plus a bias into one neuron result.
// Define NEURON_ACC_SAT_EN to clamp the result instead of wrapping.
module neuron_acc #(
  parameter int WIDTH = 32,
  parameter int NBEAT = 4,
  parameter int ACCW  = 40
) (
  input  logic        clk,
  input  logic        rst,
  neuron_acc_if.slave bus
);
  localparam int              CNTW = $clog2(NBEAT + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NBEAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACCW-1:0]  r_acc;
  logic [ACCW-1:0]  w_acc_next;
  logic [ACCW-1:0]  w_bias_x;
  logic [ACCW-1:0]  w_data_x;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_odata;
  logic [WIDTH-1:0] w_res;
  logic             w_accept;
  logic             w_last;

  assign w_bias_x = {{(ACCW-WIDTH){bus.bias[WIDTH-1]}}, bus.bias};
  assign w_data_x = {{(ACCW-WIDTH){bus.i_data[WIDTH-1]}}, bus.i_data};

  // The first beat of a result restarts from the bias, so no clear is needed.
  assign w_accept   = bus.i_valid && (r_state != OUT);
  assign w_acc_next = (r_state == IDLE) ? (w_bias_x + w_data_x) : (r_acc + w_data_x);
  assign w_last     = (r_state == IDLE) ? (NBEAT == 1) : (r_cnt == LAST);

  assign bus.i_ready = (r_state != OUT);
  assign bus.o_valid = (r_state == OUT);
  assign bus.o_data  = r_odata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACC: begin
        if (w_accept) begin
          w_next = w_last ? OUT : ACC;
        end
      end
      OUT: begin
        if (bus.o_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_odata <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_cnt <= (r_state == IDLE) ? CNTW'(1) : (r_cnt + 1'b1);
      if (w_last) begin
        r_odata <= w_res;
      end
    end
  end

`ifdef NEURON_ACC_SAT_EN
  logic [ACCW-WIDTH:0] w_hi;
  logic                w_sat;
  logic                r_sat;

  // The value fits in WIDTH bits only when every bit above the result's sign bit matches it.
  assign w_hi  = w_acc_next[ACCW-1:WIDTH-1];
  assign w_sat = !((&w_hi) || !(|w_hi));

  always_comb begin
    w_res = w_acc_next[WIDTH-1:0];
    if (w_sat) begin
      w_res = w_acc_next[ACCW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_accept && w_last) begin
      r_sat <= w_sat;
    end
  end

  assign bus.o_sat = r_sat;
`else
  assign w_res     = w_acc_next[WIDTH-1:0];
  assign bus.o_sat = 1'b0;
`endif
endmodule

// File: tb/tb_neuron_acc.sv
// Directed bench for neuron_acc: an NBEAT=4 instance plus an NBEAT=1 instance.
// Expected overflow values follow NEURON_ACC_SAT_EN.
module tb_neuron_acc;
  logic clk;
  logic rst;
  int   vecCount;
  int   missCount;

  neuron_acc_if #(.WIDTH(32)) bus0 ();
  neuron_acc_if #(.WIDTH(32)) bus1 ();

  neuron_acc #(.WIDTH(32), .NBEAT(4), .ACCW(40)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  neuron_acc #(.WIDTH(32), .NBEAT(1), .ACCW(34)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [31:0] b);
    bus0.i_valid = v;
    bus0.i_data  = d;
    bus0.bias    = b;
    tick();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus0.i_valid = 1'b1;
    bus0.i_data  = 32'd555;
    bus0.bias    = 32'd777;
    bus0.o_ready = 1'b1;
    tick();
    tick();
    rst          = 1'b0;
    bus0.i_valid = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_o_valid got %b want 0", bus0.o_valid);
    end
    vecCount++;
    if (bus0.o_data !== 32'd0) begin
      missCount++;
      $display("[TB] FAIL reset_o_data got %h want 00000000", bus0.o_data);
    end
    vecCount++;
    if (bus0.o_sat !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_o_sat got %b want 0", bus0.o_sat);
    end
    vecCount++;
    if (bus0.i_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL reset_i_ready got %b want 1", bus0.i_ready);
    end
  endtask

  task automatic test_basic();
    bus0.o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'(k + 1), 32'd10);
      if (k < 3) begin
        vecCount++;
        if (bus0.o_valid !== 1'b0) begin
          missCount++;
          $display("[TB] FAIL basic_early_valid beat %0d got %b want 0", k, bus0.o_valid);
        end
      end
    end
    bus0.i_valid = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL basic_o_valid got %b want 1", bus0.o_valid);
    end
    vecCount++;
    if (bus0.o_data !== 32'd20) begin
      missCount++;
      $display("[TB] FAIL basic_o_data got %h want 00000014", bus0.o_data);
    end
    vecCount++;
    if (bus0.o_sat !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL basic_o_sat got %b want 0", bus0.o_sat);
    end
    vecCount++;
    if (bus0.i_ready !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL basic_i_ready_out got %b want 0", bus0.i_ready);
    end
    tick();
    vecCount++;
    if (bus0.o_valid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL basic_one_cycle got %b want 0", bus0.o_valid);
    end
  endtask

  task automatic test_bubbles();
    logic        vb[7];
    logic [31:0] db[7];
    vb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    db = '{32'd7, 32'd1000, 32'hFFFF_FFFE, 32'd1000, 32'd1000, 32'd9, 32'd1};
    bus0.o_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vb[k], db[k], (k == 0) ? 32'hFFFF_FFFB : 32'd100);
      if (k < 6) begin
        vecCount++;
        if (bus0.o_valid !== 1'b0) begin
          missCount++;
          $display("[TB] FAIL bubble_early_valid step %0d got %b want 0", k, bus0.o_valid);
        end
      end
    end
    bus0.i_valid = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL bubble_o_valid got %b want 1", bus0.o_valid);
    end
    vecCount++;
    if (bus0.o_data !== 32'd10) begin
      missCount++;
      $display("[TB] FAIL bubble_o_data got %h want 0000000a", bus0.o_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus0.o_ready = 1'b0;
    applyStimulus(1'b1, 32'd5, 32'd0);
    applyStimulus(1'b1, 32'd6, 32'd0);
    applyStimulus(1'b1, 32'd7, 32'd0);
    applyStimulus(1'b1, 32'd8, 32'd0);
    bus0.i_data = 32'd99;
    bus0.bias   = 32'd1;
    for (int k = 0; k < 3; k++) begin
      vecCount++;
      if (bus0.o_valid !== 1'b1) begin
        missCount++;
        $display("[TB] FAIL stall_o_valid cycle %0d got %b want 1", k, bus0.o_valid);
      end
      vecCount++;
      if (bus0.o_data !== 32'd26) begin
        missCount++;
        $display("[TB] FAIL stall_o_data cycle %0d got %h want 0000001a", k, bus0.o_data);
      end
      vecCount++;
      if (bus0.i_ready !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL stall_i_ready cycle %0d got %b want 0", k, bus0.i_ready);
      end
      tick();
    end
    bus0.o_ready = 1'b1;
    tick();
    vecCount++;
    if (bus0.o_valid !== 1'b0 || bus0.i_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL release_state got valid=%b ready=%b want valid=0 ready=1",
               bus0.o_valid, bus0.i_ready);
    end
    applyStimulus(1'b1, 32'd99, 32'd1);
    applyStimulus(1'b1, 32'd0, 32'd50);
    applyStimulus(1'b1, 32'd0, 32'd50);
    vecCount++;
    if (bus0.o_valid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL release_early_valid got %b want 0", bus0.o_valid);
    end
    applyStimulus(1'b1, 32'd0, 32'd50);
    bus0.i_valid = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b1 || bus0.o_data !== 32'd100) begin
      missCount++;
      $display("[TB] FAIL release_result got valid=%b data=%h want valid=1 data=00000064",
               bus0.o_valid, bus0.o_data);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [31:0] expPos;
    logic [31:0] expNeg;
    logic        expSat;
`ifdef NEURON_ACC_SAT_EN
    expPos = 32'h7FFF_FFFF;
    expNeg = 32'h8000_0000;
    expSat = 1'b1;
`else
    expPos = 32'hFFFF_FFFC;
    expNeg = 32'h0000_0000;
    expSat = 1'b0;
`endif
    bus0.o_ready = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd0);
    bus0.i_valid = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b1 || bus0.o_data !== expPos) begin
      missCount++;
      $display("[TB] FAIL ovf_pos_data got valid=%b data=%h want valid=1 data=%h",
               bus0.o_valid, bus0.o_data, expPos);
    end
    vecCount++;
    if (bus0.o_sat !== expSat) begin
      missCount++;
      $display("[TB] FAIL ovf_pos_sat got %b want %b", bus0.o_sat, expSat);
    end
    tick();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h8000_0000, 32'd0);
    bus0.i_valid = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b1 || bus0.o_data !== expNeg) begin
      missCount++;
      $display("[TB] FAIL ovf_neg_data got valid=%b data=%h want valid=1 data=%h",
               bus0.o_valid, bus0.o_data, expNeg);
    end
    vecCount++;
    if (bus0.o_sat !== expSat) begin
      missCount++;
      $display("[TB] FAIL ovf_neg_sat got %b want %b", bus0.o_sat, expSat);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus0.o_ready = 1'b1;
    applyStimulus(1'b1, 32'd100, 32'd50);
    applyStimulus(1'b1, 32'd100, 32'd50);
    rst = 1'b1;
    applyStimulus(1'b1, 32'd77, 32'd50);
    rst          = 1'b0;
    bus0.i_valid = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b0 || bus0.i_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL midreset_state got valid=%b ready=%b want valid=0 ready=1",
               bus0.o_valid, bus0.i_ready);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'd1, 32'd1);
    bus0.i_valid = 1'b0;
    bus0.o_ready = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b1 || bus0.o_data !== 32'd5) begin
      missCount++;
      $display("[TB] FAIL midreset_result got valid=%b data=%h want valid=1 data=00000005",
               bus0.o_valid, bus0.o_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecCount++;
    if (bus0.o_valid !== 1'b0 || bus0.o_data !== 32'd0) begin
      missCount++;
      $display("[TB] FAIL outreset_state got valid=%b data=%h want valid=0 data=00000000",
               bus0.o_valid, bus0.o_data);
    end
    bus0.o_ready = 1'b1;
  endtask

  task automatic test_nbeat1();
    bus1.o_ready = 1'b1;
    bus1.bias    = 32'd3;
    bus1.i_valid = 1'b1;
    bus1.i_data  = 32'd4;
    tick();
    bus1.i_data = 32'hFFFF_FFF7;
    vecCount++;
    if (bus1.o_valid !== 1'b1 || bus1.o_data !== 32'd7) begin
      missCount++;
      $display("[TB] FAIL nb1_first got valid=%b data=%h want valid=1 data=00000007",
               bus1.o_valid, bus1.o_data);
    end
    tick();
    vecCount++;
    if (bus1.o_valid !== 1'b0 || bus1.i_ready !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL nb1_gap got valid=%b ready=%b want valid=0 ready=1",
               bus1.o_valid, bus1.i_ready);
    end
    tick();
    bus1.i_valid = 1'b0;
    vecCount++;
    if (bus1.o_valid !== 1'b1 || bus1.o_data !== 32'hFFFF_FFFA) begin
      missCount++;
      $display("[TB] FAIL nb1_second got valid=%b data=%h want valid=1 data=fffffffa",
               bus1.o_valid, bus1.o_data);
    end
    tick();
    vecCount++;
    if (bus1.o_valid !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL nb1_drain got %b want 0", bus1.o_valid);
    end
  endtask

  initial begin
    vecCount     = 0;
    missCount    = 0;
    rst          = 1'b1;
    bus0.i_valid = 1'b0;
    bus0.i_data  = '0;
    bus0.bias    = '0;
    bus0.o_ready = 1'b0;
    bus1.i_valid = 1'b0;
    bus1.i_data  = '0;
    bus1.bias    = '0;
    bus1.o_ready = 1'b1;
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_nbeat1();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
